// File: rtl/hub_scan_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : hub_scan_shifter
//  Description : Output stage of the LED matrix core. Scans one bit-plane out
//                of the line/frame buffer for three HUB connectors per START.
//                Each scan row is fetched column by column and shifted onto the
//                27 HUB data lines with HUB_CLK. HUB_LATCH is pulsed per row
//                and HUB_ADDR is stepped through 0..ROWS-1.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    COLS       pixels shifted per scan row per chain (>= 2)
//    ROWS       scan addresses per plane (<= 32)
//    CLK_DIV    MCLK_IN cycles per HUB_CLK half-period (>= 1)
//    LATCH_POS  1: latch overlaps the last pixel, 0: latch after last pixel
//  Ports
//    MCLK_IN     in   1    clock, rising edge
//    RESET       in   1    synchronous, active-high reset
//    START       in   1    single-cycle pulse, starts one plane scan
//    BUSY        out  1    scan in progress
//    RD_ROW      out  5    buffer row being read
//    RD_ADDR     out  AW   buffer column being read
//    RD_DATA     in   27   buffer data, valid one cycle after RD_ROW/RD_ADDR
//    HUB_DATA    out  27   {HUB3 BGR, HUB2 BGR, HUB1 BGR}
//    HUB_CLK     out  1    shift clock
//    HUB_LATCH   out  1    latch strobe
//    HUB_ADDR    out  5    scan address to the panels
//    ROW_DONE    out  1    one-cycle pulse per completed row
//    FRAME_DONE  out  1    one-cycle pulse after the last row
// ============================================================================
module hub_scan_shifter #(
    parameter int COLS      = 120,
    parameter int ROWS      = 30,
    parameter int CLK_DIV   = 1,
    parameter int LATCH_POS = 1
) (
    input  logic                     MCLK_IN,
    input  logic                     RESET,
    input  logic                     START,
    output logic                     BUSY,
    output logic [4:0]               RD_ROW,
    output logic [$clog2(COLS)-1:0]  RD_ADDR,
    input  logic [26:0]              RD_DATA,
    output logic [26:0]              HUB_DATA,
    output logic                     HUB_CLK,
    output logic                     HUB_LATCH,
    output logic [4:0]               HUB_ADDR,
    output logic                     ROW_DONE,
    output logic                     FRAME_DONE
);

    localparam int AW = $clog2(COLS);
    // Phase counter covers both a half-period and the 2*CLK_DIV latch window.
    localparam int CW = $clog2(2 * CLK_DIV);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_FETCH    = 3'd1;
    localparam logic [2:0] c_SHIFT_LO = 3'd2;
    localparam logic [2:0] c_SHIFT_HI = 3'd3;
    localparam logic [2:0] c_LATCH    = 3'd4;
    localparam logic [2:0] c_NEXT_ROW = 3'd5;

    localparam logic [CW-1:0] c_PH_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] c_LAT_LAST  = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] c_ONE_C     = CW'(1);
    localparam logic [AW-1:0] c_PIX_LAST  = AW'(COLS - 1);
    localparam logic [AW-1:0] c_PIX_PEN   = AW'(COLS - 2);
    localparam logic [AW-1:0] c_ONE_A     = AW'(1);
    localparam logic [4:0]    c_ROW_LAST  = 5'(ROWS - 1);

    logic [2:0]    state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [AW-1:0] pix_q,       pix_d;        // pixel currently on HUB_DATA
    logic [4:0]    row_q,       row_d;        // row currently being shifted
    logic [4:0]    rd_row_q,    rd_row_d;
    logic [AW-1:0] rd_addr_q,   rd_addr_d;
    logic [26:0]   hub_data_q,  hub_data_d;
    logic          hub_clk_q,   hub_clk_d;
    logic          hub_latch_q, hub_latch_d;
    logic [4:0]    hub_addr_q,  hub_addr_d;
    logic          row_done_q,  row_done_d;
    logic          frame_done_q, frame_done_d;
    logic          busy_q,      busy_d;

    logic          w_enter_row;   // last pixel (or latch window) finished
    logic          w_load;        // capture RD_DATA into HUB_DATA this cycle
    logic [AW-1:0] w_addr_inc;

    // RD_ADDR saturates on the last column; the row wrap resets it.
    assign w_addr_inc = (rd_addr_q == c_PIX_LAST) ? rd_addr_q : rd_addr_q + c_ONE_A;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pix_d        = pix_q;
        row_d        = row_q;
        rd_row_d     = rd_row_q;
        rd_addr_d    = rd_addr_q;
        hub_data_d   = hub_data_q;
        hub_clk_d    = hub_clk_q;
        hub_latch_d  = hub_latch_q;
        hub_addr_d   = hub_addr_q;
        row_done_d   = 1'b0;
        frame_done_d = 1'b0;
        busy_d       = busy_q;
        w_enter_row  = 1'b0;
        w_load       = 1'b0;

        case (state_q)
            c_IDLE: begin
                if (START) begin
                    state_d   = c_FETCH;
                    busy_d    = 1'b1;
                    row_d     = 5'd0;
                    rd_row_d  = 5'd0;
                    rd_addr_d = '0;
                end
            end

            c_FETCH: begin
                // Address (row, 0) has been on the read port since the
                // previous cycle, so RD_DATA already holds pixel 0.
                w_load  = 1'b1;
                pix_d   = '0;
                state_d = c_SHIFT_LO;
            end

            c_SHIFT_LO: begin
                if (cnt_q == c_PH_LAST) begin
                    cnt_d     = '0;
                    hub_clk_d = 1'b1;
                    state_d   = c_SHIFT_HI;
                end else begin
                    cnt_d = cnt_q + c_ONE_C;
                end
            end

            c_SHIFT_HI: begin
                if (cnt_q == c_PH_LAST) begin
                    cnt_d     = '0;
                    hub_clk_d = 1'b0;
                    if (pix_q != c_PIX_LAST) begin
                        w_load  = 1'b1;
                        pix_d   = pix_q + c_ONE_A;
                        state_d = c_SHIFT_LO;
                        // Overlapping latch spans the whole last pixel.
                        if (LATCH_POS != 0 && pix_q == c_PIX_PEN) begin
                            hub_latch_d = 1'b1;
                        end
                    end else if (LATCH_POS == 0) begin
                        hub_latch_d = 1'b1;
                        state_d     = c_LATCH;
                    end else begin
                        w_enter_row = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + c_ONE_C;
                end
            end

            c_LATCH: begin
                if (cnt_q == c_LAT_LAST) begin
                    cnt_d       = '0;
                    w_enter_row = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_ONE_C;
                end
            end

            c_NEXT_ROW: begin
                if (row_q == c_ROW_LAST) begin
                    row_d   = 5'd0;
                    busy_d  = 1'b0;
                    state_d = c_IDLE;
                end else begin
                    row_d   = row_q + 5'd1;
                    state_d = c_FETCH;
                end
            end

            default: begin
                state_d = c_IDLE;
            end
        endcase

        if (w_load) begin
            hub_data_d = RD_DATA;
            hub_clk_d  = 1'b0;
            rd_addr_d  = w_addr_inc;
        end

        if (w_enter_row) begin
            state_d      = c_NEXT_ROW;
            hub_latch_d  = 1'b0;
            hub_clk_d    = 1'b0;
            hub_addr_d   = row_q;
            row_done_d   = 1'b1;
            frame_done_d = (row_q == c_ROW_LAST);
            // Read port moves to the next row's column 0 one cycle ahead of
            // FETCH, which hides the one-cycle buffer latency at the row start.
            rd_addr_d    = '0;
            rd_row_d     = (row_q == c_ROW_LAST) ? 5'd0 : row_q + 5'd1;
        end
    end

    always_ff @(posedge MCLK_IN) begin
        if (RESET) begin
            state_q      <= c_IDLE;
            cnt_q        <= '0;
            pix_q        <= '0;
            row_q        <= '0;
            rd_row_q     <= '0;
            rd_addr_q    <= '0;
            hub_data_q   <= '0;
            hub_clk_q    <= 1'b0;
            hub_latch_q  <= 1'b0;
            hub_addr_q   <= '0;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pix_q        <= pix_d;
            row_q        <= row_d;
            rd_row_q     <= rd_row_d;
            rd_addr_q    <= rd_addr_d;
            hub_data_q   <= hub_data_d;
            hub_clk_q    <= hub_clk_d;
            hub_latch_q  <= hub_latch_d;
            hub_addr_q   <= hub_addr_d;
            row_done_q   <= row_done_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign BUSY       = busy_q;
    assign RD_ROW     = rd_row_q;
    assign RD_ADDR    = rd_addr_q;
    assign HUB_DATA   = hub_data_q;
    assign HUB_CLK    = hub_clk_q;
    assign HUB_LATCH  = hub_latch_q;
    assign HUB_ADDR   = hub_addr_q;
    assign ROW_DONE   = row_done_q;
    assign FRAME_DONE = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_hub_scan_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hub_scan_shifter
//  Description : Self-checking bench for hub_scan_shifter. Four instances
//                cover the default array, CLK_DIV=3, and both latch
//                positions on a 4x2 array. Expected outputs per cycle come
//                from a closed-form timing model of one plane scan.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hub_scan_shifter;

    logic clk;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic        start_a [4];
    logic        rst_a   [4];
    logic [26:0] rd_data [4];
    logic        busy_w  [4];
    logic [4:0]  rd_row_w[4];
    logic [26:0] hdata_w [4];
    logic        hclk_w  [4];
    logic        hlat_w  [4];
    logic [4:0]  haddr_w [4];
    logic        rdone_w [4];
    logic        fdone_w [4];
    logic [63:0] obs_vec [4];
    logic [6:0]  rda0;
    logic [3:0]  rda1;
    logic [1:0]  rda2;
    logic [1:0]  rda3;

    int unsigned seed  [4];
    logic [4:0]  paddr [4];   // HUB_ADDR expected before a scan's first row ends
    logic [26:0] pdata [4];   // HUB_DATA expected before a scan's first load

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- configuration table ----------------
    function automatic int p_cols(input int i);
        case (i) 0: return 120; 1: return 16; default: return 4; endcase
    endfunction
    function automatic int p_rows(input int i);
        case (i) 0: return 30; 1: return 4; default: return 2; endcase
    endfunction
    function automatic int p_cd(input int i);
        case (i) 1: return 3; default: return 1; endcase
    endfunction
    function automatic int p_lp(input int i);
        case (i) 1: return 0; 2: return 0; default: return 1; endcase
    endfunction
    function automatic int p_period(input int i);
        return 2 + 2 * p_cd(i) * p_cols(i) + ((p_lp(i) != 0) ? 0 : 2 * p_cd(i));
    endfunction

    // Buffer content: a hash of (row, column) mixed with a per-scan seed.
    function automatic logic [26:0] pix_hash(input int unsigned s, input int r, input int c);
        int unsigned v;
        v = (int'(r) * 1103 + int'(c) * 97 + 13) * 32'h9E3779B1;
        v = v ^ s;
        v = v ^ (v >> 13);
        return v[26:0];
    endfunction

    // ---------------- DUT instances ----------------
    hub_scan_shifter #(.COLS(120), .ROWS(30), .CLK_DIV(1), .LATCH_POS(1)) u_dut0 (
        .MCLK_IN(clk), .RESET(rst_a[0]), .START(start_a[0]), .BUSY(busy_w[0]),
        .RD_ROW(rd_row_w[0]), .RD_ADDR(rda0), .RD_DATA(rd_data[0]),
        .HUB_DATA(hdata_w[0]), .HUB_CLK(hclk_w[0]), .HUB_LATCH(hlat_w[0]),
        .HUB_ADDR(haddr_w[0]), .ROW_DONE(rdone_w[0]), .FRAME_DONE(fdone_w[0]));
    hub_scan_shifter #(.COLS(16), .ROWS(4), .CLK_DIV(3), .LATCH_POS(0)) u_dut1 (
        .MCLK_IN(clk), .RESET(rst_a[1]), .START(start_a[1]), .BUSY(busy_w[1]),
        .RD_ROW(rd_row_w[1]), .RD_ADDR(rda1), .RD_DATA(rd_data[1]),
        .HUB_DATA(hdata_w[1]), .HUB_CLK(hclk_w[1]), .HUB_LATCH(hlat_w[1]),
        .HUB_ADDR(haddr_w[1]), .ROW_DONE(rdone_w[1]), .FRAME_DONE(fdone_w[1]));
    hub_scan_shifter #(.COLS(4), .ROWS(2), .CLK_DIV(1), .LATCH_POS(0)) u_dut2 (
        .MCLK_IN(clk), .RESET(rst_a[2]), .START(start_a[2]), .BUSY(busy_w[2]),
        .RD_ROW(rd_row_w[2]), .RD_ADDR(rda2), .RD_DATA(rd_data[2]),
        .HUB_DATA(hdata_w[2]), .HUB_CLK(hclk_w[2]), .HUB_LATCH(hlat_w[2]),
        .HUB_ADDR(haddr_w[2]), .ROW_DONE(rdone_w[2]), .FRAME_DONE(fdone_w[2]));
    hub_scan_shifter #(.COLS(4), .ROWS(2), .CLK_DIV(1), .LATCH_POS(1)) u_dut3 (
        .MCLK_IN(clk), .RESET(rst_a[3]), .START(start_a[3]), .BUSY(busy_w[3]),
        .RD_ROW(rd_row_w[3]), .RD_ADDR(rda3), .RD_DATA(rd_data[3]),
        .HUB_DATA(hdata_w[3]), .HUB_CLK(hclk_w[3]), .HUB_LATCH(hlat_w[3]),
        .HUB_ADDR(haddr_w[3]), .ROW_DONE(rdone_w[3]), .FRAME_DONE(fdone_w[3]));

    // Synchronous buffer read port: one cycle of latency.
    always @(posedge clk) begin
        rd_data[0] <= pix_hash(seed[0], int'(rd_row_w[0]), int'(rda0));
        rd_data[1] <= pix_hash(seed[1], int'(rd_row_w[1]), int'(rda1));
        rd_data[2] <= pix_hash(seed[2], int'(rd_row_w[2]), int'(rda2));
        rd_data[3] <= pix_hash(seed[3], int'(rd_row_w[3]), int'(rda3));
    end

    // Bit map: [36] BUSY [35] HUB_CLK [34] HUB_LATCH [33] ROW_DONE
    //          [32] FRAME_DONE [31:27] HUB_ADDR [26:0] HUB_DATA
    for (genvar k = 0; k < 4; k++) begin : g_obs
        assign obs_vec[k] = {27'd0, busy_w[k], hclk_w[k], hlat_w[k], rdone_w[k],
                             fdone_w[k], haddr_w[k], hdata_w[k]};
    end

    // ---------------- reference model ----------------
    // Expected outputs t cycles after the cycle in which START was driven
    // (t = 0 is that idle cycle itself).
    function automatic logic [63:0] exp_vec(input int i, input int t, input int unsigned s,
                                            input logic [4:0] pa, input logic [26:0] pd);
        int cols, rows, cd, per, npix, r, k, p, ph;
        logic busy, hc, lat, rdn, fdn;
        logic [4:0]  a;
        logic [26:0] d;
        cols = p_cols(i); rows = p_rows(i); cd = p_cd(i); per = p_period(i);
        npix = 2 * cd * cols;
        busy = 1'b0; hc = 1'b0; lat = 1'b0; rdn = 1'b0; fdn = 1'b0;
        a = pa; d = pd;
        if (t >= 1 && t <= rows * per) begin
            r = (t - 1) / per;
            k = (t - 1) % per;
            busy = 1'b1;
            if (r > 0) begin
                a = 5'(r - 1);
                d = pix_hash(s, r - 1, cols - 1);
            end
            if (k >= 1 && k <= npix) begin
                p   = (k - 1) / (2 * cd);
                ph  = (k - 1) % (2 * cd);
                d   = pix_hash(s, r, p);
                hc  = (ph >= cd);
                lat = (p_lp(i) != 0) && (p == cols - 1);
            end else if (k > npix && k < per - 1) begin
                d   = pix_hash(s, r, cols - 1);
                lat = 1'b1;
            end else if (k == per - 1) begin
                d   = pix_hash(s, r, cols - 1);
                a   = 5'(r);
                rdn = 1'b1;
                fdn = (r == rows - 1);
            end
        end
        return {27'd0, busy, hc, lat, rdn, fdn, a, d};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    // Drives one START (plus optional ignored STARTs while busy) and checks
    // every cycle up to t = tlen. With chain set, START is also driven in
    // the FRAME_DONE cycle and left high into the first idle cycle.
    task automatic scan(input int i, input int tlen, input bit chain, input bit noise);
        int   rises, rdn, lats;
        logic prev_clk;
        logic [63:0] o;
        rises = 0; rdn = 0; lats = 0; prev_clk = 1'b0;
        for (int t = 0; t <= tlen; t++) begin
            @(negedge clk);
            o = obs_vec[i];
            check_eq($sformatf("u%0d_t%0d", i, t), o, exp_vec(i, t, seed[i], paddr[i], pdata[i]));
            if (o[35] && !prev_clk) rises++;
            prev_clk = o[35];
            rdn  += int'(o[33]);
            lats += int'(o[34]);
            start_a[i] = (t == 0) || (t < tlen && noise && $urandom_range(0, 15) == 0)
                         || (t == tlen && chain);
        end
        if (tlen == p_rows(i) * p_period(i)) begin
            check_eq($sformatf("u%0d_rises", i), 64'(rises), 64'(p_rows(i) * p_cols(i)));
            check_eq($sformatf("u%0d_row_done", i), 64'(rdn), 64'(p_rows(i)));
            check_eq($sformatf("u%0d_latch_cyc", i), 64'(lats), 64'(p_rows(i) * 2 * p_cd(i)));
            paddr[i] = 5'(p_rows(i) - 1);
            pdata[i] = pix_hash(seed[i], p_rows(i) - 1, p_cols(i) - 1);
        end
    endtask

    task automatic full_pair(input int i);
        int tf;
        tf = p_rows(i) * p_period(i);
        scan(i, tf, 1'b1, 1'b1);
        seed[i] = $urandom;
        scan(i, tf, 1'b0, 1'b1);
    endtask

    initial begin
        int tr;
        for (int i = 0; i < 4; i++) begin
            start_a[i] = 1'b0;
            rst_a[i]   = 1'b1;
            seed[i]    = $urandom;
            paddr[i]   = '0;
            pdata[i]   = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) check_eq($sformatf("reset_u%0d", i), obs_vec[i], 64'd0);
        check_eq("reset_rd", {52'd0, rd_row_w[0], rda0}, 64'd0);
        for (int i = 0; i < 4; i++) rst_a[i] = 1'b0;

        full_pair(2);
        full_pair(3);
        full_pair(1);
        full_pair(0);

        // Reset in the middle of a pixel on row 5 of the default array.
        seed[0] = $urandom;
        tr = 5 * p_period(0) + 1 + int'($urandom_range(1, 2 * p_cols(0) - 1));
        scan(0, tr, 1'b0, 1'b1);
        rst_a[0] = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_outs", obs_vec[0], 64'd0);
        check_eq("rst_mid_rd", {52'd0, rd_row_w[0], rda0}, 64'd0);
        rst_a[0] = 1'b0;
        paddr[0] = '0;
        pdata[0] = '0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check_eq("rst_idle", obs_vec[0], exp_vec(0, 0, seed[0], paddr[0], pdata[0]));
        end
        // Restart must begin at row 0, column 0.
        scan(0, p_period(0) + 20, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
